echo_initiator: RTL and testbench

- Initiator end of the byte echo protocol; the responder returns every received byte and stops after 0x55.
- Sends a deterministic payload of LEN bytes followed by the 0x55 terminator, one byte at a time over the UART tx interface.
- Waits for each echo on the rx interface and compares it with the byte sent; counts mismatches and detects a missing echo.
- Sits beside the UART tx/rx cores as a link self-test engine, started by the top-level controller through activate/done.

---
 rtl/echo_initiator_if.sv | 11 +
 rtl/echo_initiator.sv | 111 +++++++++++
 tb/tb_echo_initiator.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/echo_initiator_if.sv
// UART-side bundle of the echo initiator: transmit request path and receive strobe path.
interface echo_initiator_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_active;
   logic       rx_ready;
   logic [7:0] rx_data;

   modport master (output tx_data, tx_start, input tx_active, rx_ready, rx_data);
   modport slave  (input tx_data, tx_start, output tx_active, rx_ready, rx_data);
endinterface

// File: rtl/echo_initiator.sv
// Link self-test: sends LEN payload bytes plus a 0x55 terminator, checks each echo,
// counts mismatches and aborts if an echo fails to arrive within TIMEOUT cycles.
module echo_initiator #(
   parameter int         LEN     = 16,
   parameter logic [7:0] SEED    = 8'h00,
   parameter int         TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             activate,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [7:0]       err_count,
   echo_initiator_if.master uart
);
   localparam int            TW     = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    TERM   = 8'h55;
   localparam logic [7:0]    SEED0  = (SEED == TERM) ? 8'h56 : SEED;
   localparam logic [7:0]    K_LAST = 8'(LEN);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, ECHO, DONE} state_t;

   state_t        state;
   logic [7:0]    k;
   logic [7:0]    value;
   logic [TW-1:0] timer;
   logic          last;
   logic [7:0]    cur_byte;
   logic [7:0]    err_next;
   logic [7:0]    value_inc;

   // The terminator value never appears in the payload, so the responder's stop rule is unambiguous.
   always_comb begin
      last      = (k == K_LAST);
      cur_byte  = last ? TERM : value;
      err_next  = err_count;
      if ((uart.rx_data != uart.tx_data) && (err_count != 8'hFF))
         err_next = err_count + 8'd1;
      value_inc = value + 8'd1;
      if (value_inc == TERM)
         value_inc = 8'h56;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         done          <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         err_count     <= 8'd0;
         uart.tx_data  <= 8'd0;
         uart.tx_start <= 1'b0;
         k             <= 8'd0;
         value         <= 8'd0;
         timer         <= '0;
      end else begin
         uart.tx_start <= 1'b0;
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (activate) begin
                  err_count <= 8'd0;
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  value     <= SEED0;
                  k         <= 8'd0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (!uart.tx_active) begin
                  uart.tx_data  <= cur_byte;
                  uart.tx_start <= 1'b1;
                  timer         <= '0;
                  state         <= ECHO;
               end
            end
            ECHO: begin
               timer <= timer + 1'b1;
               // An echo arriving on the limit cycle still counts as received.
               if (uart.rx_ready) begin
                  err_count <= err_next;
                  if (last) begin
                     done  <= 1'b1;
                     pass  <= (err_next == 8'd0);
                     state <= DONE;
                  end else begin
                     k     <= k + 8'd1;
                     value <= value_inc;
                     state <= LOAD;
                  end
               end else if (timer == T_LAST) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  pass    <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (!activate && !uart.rx_ready) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_echo_initiator.sv
// Directed + randomized-timing bench for echo_initiator against a byte-list reference model.
module tb_echo_initiator;
   logic       clk;
   logic       reset;
   logic       a_act, a_done, a_pass, a_to;
   logic [7:0] a_err;
   logic       b_act, b_done, b_pass, b_to;
   logic [7:0] b_err;

   logic [7:0] a_sent[$];
   logic [7:0] b_sent[$];
   logic [7:0] exp_q[$];
   int         errors, checks, viol, n_start, n_done;

   echo_initiator_if a_if();
   echo_initiator_if b_if();

   echo_initiator #(.LEN(8), .SEED(8'h50), .TIMEOUT(100)) dut_a (
      .clk(clk), .reset(reset), .activate(a_act), .done(a_done), .pass(a_pass),
      .timeout(a_to), .err_count(a_err), .uart(a_if));

   echo_initiator #(.LEN(255), .SEED(8'hA0), .TIMEOUT(100)) dut_b (
      .clk(clk), .reset(reset), .activate(b_act), .done(b_done), .pass(b_pass),
      .timeout(b_to), .err_count(b_err), .uart(b_if));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference byte stream: payload counts up from seed, 0x55 skipped, terminator appended.
   function automatic void build_exp(input int len, input int seed);
      int v;
      exp_q.delete();
      v = seed;
      for (int i = 0; i < len; i++) begin
         if (v % 256 == 'h55) v++;
         exp_q.push_back(8'(v % 256));
         v++;
      end
      exp_q.push_back(8'h55);
   endfunction

   // Responder for DUT A with random echo delay and random transmitter-busy time.
   task automatic run_a(input int bad_idx, input logic [7:0] bad_val, input bit silent,
                        input int drop_at, input int stop_tx);
      int pend, busy;
      bit prev_busy;
      a_sent.delete();
      viol = 0; n_start = -1; n_done = -1;
      pend = -1; busy = 0; prev_busy = 1'b0;
      a_act = 1'b1;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         if (a_done) begin n_done = cyc; break; end
         if (a_if.tx_start) begin
            if (prev_busy) viol++;
            a_sent.push_back(a_if.tx_data);
            n_start = cyc;
            if (!silent) pend = int'($urandom_range(0, 4));
            if (a_sent.size() == stop_tx) break;
         end
         if (cyc == drop_at) a_act = 1'b0;
         a_if.rx_ready = 1'b0;
         if (pend == 0) begin
            a_if.rx_ready = 1'b1;
            a_if.rx_data  = (a_sent.size() - 1 == bad_idx) ? bad_val : a_sent[a_sent.size() - 1];
            busy = int'($urandom_range(0, 3));
         end
         if (pend >= 0) pend--;
         a_if.tx_active = (busy > 0);
         prev_busy = a_if.tx_active;
         if (busy > 0) busy--;
      end
      a_if.rx_ready  = 1'b0;
      a_if.tx_active = 1'b0;
   endtask

   task automatic chk_bytes(input string tag);
      chk({tag, "_count"}, a_sent.size(), exp_q.size());
      for (int i = 0; i < a_sent.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), a_sent[i], exp_q[i]);
   endtask

   initial begin
      int n, bad;
      clk = 1'b0; errors = 0; checks = 0;
      a_act = 1'b0; b_act = 1'b0;
      a_if.tx_active = 1'b0; a_if.rx_ready = 1'b0; a_if.rx_data = 8'h00;
      b_if.tx_active = 1'b0; b_if.rx_ready = 1'b0; b_if.rx_data = 8'h00;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_done", a_done, 0);
      chk("rst_pass", a_pass, 0);
      chk("rst_timeout", a_to, 0);
      chk("rst_err", a_err, 0);
      chk("rst_tx_data", a_if.tx_data, 0);
      chk("rst_tx_start", a_if.tx_start, 0);
      reset = 1'b1;
      @(negedge clk);

      // Clean run, activate held through DONE
      build_exp(8, 'h50);
      run_a(-1, 8'h00, 1'b0, -1, -1);
      chk_bytes("clean");
      chk("clean_done", a_done, 1);
      chk("clean_pass", a_pass, 1);
      chk("clean_err", a_err, 0);
      chk("clean_timeout", a_to, 0);
      chk("clean_busy_viol", viol, 0);
      repeat (5) @(negedge clk);
      chk("clean_done_held", a_done, 1);
      a_act = 1'b0;
      @(negedge clk);
      chk("clean_done_fall", a_done, 0);
      chk("clean_pass_hold", a_pass, 1);

      // Third echo corrupted, activate dropped mid-test
      run_a(2, 8'h12, 1'b0, int'($urandom_range(2, 6)), -1);
      chk_bytes("corrupt");
      chk("corrupt_done", a_done, 1);
      chk("corrupt_err", a_err, 1);
      chk("corrupt_pass", a_pass, 0);
      chk("corrupt_timeout", a_to, 0);
      a_if.rx_ready = 1'b1; a_if.rx_data = 8'h00;
      @(negedge clk);
      a_if.rx_ready = 1'b0;
      chk("done_rx_hold", a_done, 1);
      chk("done_rx_ignored", a_err, 1);
      @(negedge clk);
      chk("corrupt_done_fall", a_done, 0);
      chk("corrupt_err_hold", a_err, 1);
      chk("corrupt_pass_hold", a_pass, 0);

      // Silent responder
      run_a(-1, 8'h00, 1'b1, -1, -1);
      chk("to_tx_count", a_sent.size(), 1);
      chk("to_latency", n_done - n_start, 100);
      chk("to_timeout", a_to, 1);
      chk("to_done", a_done, 1);
      chk("to_pass", a_pass, 0);
      a_act = 1'b0;
      @(negedge clk);
      chk("to_done_fall", a_done, 0);
      chk("to_timeout_hold", a_to, 1);

      // Transmitter busy for 100 cycles after activate
      a_if.tx_active = 1'b1; a_act = 1'b1;
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_if.tx_start) n++;
      end
      chk("busy_no_start", n, 0);
      a_if.tx_active = 1'b0;
      @(negedge clk);
      chk("busy_start", a_if.tx_start, 1);
      chk("busy_data", a_if.tx_data, 8'h50);
      chk("busy_timeout_clr", a_to, 0);
      @(negedge clk);
      chk("busy_one_pulse", a_if.tx_start, 0);
      a_act = 1'b0; reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset while waiting on the fourth echo, with an earlier error counted
      run_a(1, 8'hEE, 1'b0, -1, 4);
      chk("mid_tx_count", a_sent.size(), 4);
      chk("mid_byte3", a_sent[3], exp_q[3]);
      chk("mid_err", a_err, 1);
      reset = 1'b0; a_act = 1'b0;
      #1;
      chk("mid_rst_tx_start", a_if.tx_start, 0);
      chk("mid_rst_tx_data", a_if.tx_data, 0);
      chk("mid_rst_err", a_err, 0);
      chk("mid_rst_done", a_done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_a(-1, 8'h00, 1'b0, -1, -1);
      chk_bytes("restart");
      chk("restart_err", a_err, 0);
      chk("restart_pass", a_pass, 1);
      a_act = 1'b0;
      @(negedge clk);

      // Every echo wrong on a 255-byte run: error count saturates
      build_exp(255, 'hA0);
      b_sent.delete();
      b_act = 1'b1;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         if (b_done) break;
         b_if.rx_ready = 1'b0;
         if (b_if.tx_start) begin
            b_sent.push_back(b_if.tx_data);
            b_if.rx_ready = 1'b1;
            b_if.rx_data  = ~b_if.tx_data;
         end
      end
      b_if.rx_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < b_sent.size() && i < exp_q.size(); i++)
         if (b_sent[i] !== exp_q[i]) bad++;
      chk("sat_tx_count", b_sent.size(), 256);
      chk("sat_byte_mismatch", bad, 0);
      chk("sat_done", b_done, 1);
      chk("sat_err", b_err, 255);
      chk("sat_pass", b_pass, 0);
      chk("sat_timeout", b_to, 0);
      b_act = 1'b0;
      @(negedge clk);
      chk("sat_done_fall", b_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
